// File: rtl/config_loader_pkg.sv
// Shared types and CRC constants for the configuration chain loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned CRC_WIDTH = 16;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_WIDTH-1:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/config_crc16.sv
// Serial CRC-16-CCITT, one message bit per enabled cycle, MSB-first, no reflection.
module config_crc16
  import config_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc
);

  logic                 feedback_c;
  logic [CRC_WIDTH-1:0] crc_next_c;

  always_comb begin
    feedback_c = crc[CRC_WIDTH-1] ^ bit_in;
    crc_next_c = {crc[CRC_WIDTH-2:0], 1'b0} ^ (feedback_c ? CRC_POLY : '0);
  end

  // init wins over enable so a fresh load always starts from the seed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc_next_c;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Host-word to serial bitstream loader driving the tile configuration chain head.
// Optional trailing CRC check enabled with `define CONFIG_LOADER_CRC_EN.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 384,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_error
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned BL_W  = $clog2(WORD_WIDTH + 1);

  state_t                state;
  logic [WORD_WIDTH-1:0] shift_buf;
  logic [CNT_W-1:0]      bit_count;
  logic [BL_W-1:0]       bits_left;

  logic [CNT_W-1:0]      remaining_c;
  logic [BL_W-1:0]       first_bits_c;
  logic [WORD_WIDTH-1:0] buf_shl_c;
  logic                  last_bit_c;
  logic                  accept_c;
  logic                  restart_c;

  // Bits still owed to the chain bound the size of the next word
  always_comb begin
    remaining_c  = CNT_W'(CHAIN_LENGTH) - bit_count;
    first_bits_c = (32'(remaining_c) >= WORD_WIDTH) ? BL_W'(WORD_WIDTH) : BL_W'(remaining_c);
    buf_shl_c    = shift_buf << 1;
    last_bit_c   = (bit_count == CNT_W'(CHAIN_LENGTH - 1));
    accept_c     = word_valid && word_ready;
    restart_c    = start && ((state == IDLE) || (state == DONE));
  end

`ifdef CONFIG_LOADER_CRC_EN
  localparam int unsigned CHK_WORDS = (CRC_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned ACC_W     = CHK_WORDS * WORD_WIDTH;
  localparam int unsigned CHK_W     = $clog2(CHK_WORDS + 1);

  logic [CRC_WIDTH-1:0] crc_value;
  logic [ACC_W-1:0]     rx_acc;
  logic [CHK_W-1:0]     chk_count;
  logic [ACC_W-1:0]     rx_next_c;
  logic [CRC_WIDTH-1:0] rx_ref_c;
  logic                 chk_last_c;

  // Reference CRC is the top CRC_WIDTH bits of the concatenated check words
  always_comb begin
    rx_next_c  = ACC_W'({rx_acc, word_data});
    rx_ref_c   = rx_next_c[ACC_W-1 -: CRC_WIDTH];
    chk_last_c = (chk_count == CHK_W'(CHK_WORDS - 1));
  end

  config_crc16 u_crc (
    .clk    (config_clock),
    .rst_n  (config_nreset),
    .init   (restart_c),
    .enable (config_enable),
    .bit_in (config_out),
    .crc    (crc_value)
  );
`else
  assign crc_error = 1'b0;
`endif

  always_ff @(posedge config_clock) begin
    if (!config_nreset) begin
      state         <= IDLE;
      word_ready    <= 1'b0;
      config_out    <= 1'b0;
      config_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      shift_buf     <= '0;
      bit_count     <= '0;
      bits_left     <= '0;
`ifdef CONFIG_LOADER_CRC_EN
      crc_error     <= 1'b0;
      rx_acc        <= '0;
      chk_count     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (restart_c) begin
            state      <= LOAD;
            bit_count  <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            word_ready <= 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
            crc_error  <= 1'b0;
            chk_count  <= '0;
`endif
          end
        end

        LOAD: begin
          if (accept_c) begin
            shift_buf     <= word_data;
            bits_left     <= first_bits_c;
            config_out    <= word_data[WORD_WIDTH-1];
            config_enable <= 1'b1;
            word_ready    <= 1'b0;
            state         <= SHIFT;
          end
        end

        // Each cycle here commits config_out into the chain on the next edge
        SHIFT: begin
          shift_buf <= buf_shl_c;
          bit_count <= bit_count + 1'b1;
          bits_left <= bits_left - 1'b1;
          if (last_bit_c) begin
            config_enable <= 1'b0;
            config_out    <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            state         <= CHECK;
            word_ready    <= 1'b1;
`else
            state         <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
`endif
          end else if (bits_left == BL_W'(1)) begin
            config_enable <= 1'b0;
            config_out    <= 1'b0;
            word_ready    <= 1'b1;
            state         <= LOAD;
          end else begin
            config_out    <= buf_shl_c[WORD_WIDTH-1];
          end
        end

`ifdef CONFIG_LOADER_CRC_EN
        CHECK: begin
          if (accept_c) begin
            rx_acc    <= rx_next_c;
            chk_count <= chk_count + 1'b1;
            if (chk_last_c) begin
              state      <= DONE;
              word_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              crc_error  <= (rx_ref_c != crc_value);
            end
          end
        end
`endif

        default: begin
          state         <= IDLE;
          word_ready    <= 1'b0;
          config_enable <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 24-bit and a 20-bit chain instance with serial chain models.
module tb_config_loader;

`ifdef CONFIG_LOADER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] valid = '0;
  logic [7:0] data [2];
  wire  [1:0] ready, cout, cen, busy, done, crcerr;

  logic [23:0] chain [2];
  int          en_cnt [2];
  int          last_en [2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  config_loader #(.CHAIN_LENGTH(24), .WORD_WIDTH(8)) u_dut24 (
    .config_clock (clk),      .config_nreset (rst_n),
    .start        (start[0]), .word_data     (data[0]),
    .word_valid   (valid[0]), .word_ready    (ready[0]),
    .config_out   (cout[0]),  .config_enable (cen[0]),
    .busy         (busy[0]),  .done          (done[0]),
    .crc_error    (crcerr[0])
  );

  config_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8)) u_dut20 (
    .config_clock (clk),      .config_nreset (rst_n),
    .start        (start[1]), .word_data     (data[1]),
    .word_valid   (valid[1]), .word_ready    (ready[1]),
    .config_out   (cout[1]),  .config_enable (cen[1]),
    .busy         (busy[1]),  .done          (done[1]),
    .crc_error    (crcerr[1])
  );

  // Model of the tile chain: shifts config_out in on every enabled edge
  initial begin
    for (int s = 0; s < 2; s++) begin
      chain[s] = '0; en_cnt[s] = 0; last_en[s] = 0; data[s] = '0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < 2; s++) begin
      if (cen[s]) begin
        chain[s]   <= {chain[s][22:0], cout[s]};
        en_cnt[s]  <= en_cnt[s] + 1;
        last_en[s] <= cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int s);
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
  endtask

  function automatic logic [15:0] crc_model(input logic [23:0] d, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ d[23-i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Optional idle gap with ready high, then hold valid until accepted
  task automatic send_word(input int s, input logic [7:0] w, input int gap);
    int   n;
    logic rdy;
    logic gap_en;
    if (gap > 0) begin
      n = 0;
      while (!ready[s] && n < 200) begin tick(); n++; end
      if (!ready[s]) check("gap_ready_timeout", 32'(0), 32'(1));
      gap_en = 1'b0;
      for (int i = 0; i < gap; i++) begin
        gap_en = gap_en | cen[s];
        tick();
      end
      check("gap_enable_low", 32'(gap_en), 32'(0));
    end
    data[s]  = w;
    valid[s] = 1'b1;
    n = 0;
    do begin
      rdy = ready[s];
      tick();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check("accept_timeout", 32'(0), 32'(1));
    valid[s] = 1'b0;
    data[s]  = '0;
  endtask

  task automatic run_load(input int s, input logic [23:0] d, input int gap,
                          input logic flip, input logic mid_start, output int edges);
    logic [23:0] sent;
    logic [15:0] crc;
    int          st;
    int          n;
    sent = flip ? (d ^ 24'h010000) : d;
    crc  = crc_model(d, (s == 0) ? 24 : 20);
    pulse_start(s);
    st = cyc;
    check("start_ready", 32'(ready[s]), 32'(1));
    check("start_done_clr", 32'(done[s]), 32'(0));
    for (int i = 0; i < 3; i++) begin
      send_word(s, sent[23-8*i -: 8], gap);
      if (mid_start) pulse_start(s);
    end
    if (CRC_ON) begin
      send_word(s, crc[15:8], gap);
      send_word(s, crc[7:0], gap);
    end
    n = 0;
    while (!done[s] && n < 300) begin tick(); n++; end
    if (!done[s]) check("done_timeout", 32'(0), 32'(1));
    edges = cyc - st;
  endtask

  initial begin
    int edges;
    int base;
    int n;

    tick(); tick();
    check("rst_outs_24", 32'({ready[0], cout[0], cen[0], busy[0], done[0], crcerr[0]}), 32'(0));
    check("rst_outs_20", 32'({ready[1], cout[1], cen[1], busy[1], done[1], crcerr[1]}), 32'(0));
    rst_n = 1'b1;
    tick();

    // Back-to-back words, best-case timing
    base = en_cnt[0];
    run_load(0, 24'hA50FC3, 0, 1'b0, 1'b0, edges);
    check("l24_en_cycles", 32'(en_cnt[0] - base), 32'(24));
    check("l24_chain", 32'(chain[0]), 32'h00A50FC3);
    check("l24_done_busy", 32'({done[0], busy[0], ready[0]}), 32'b100);
    check("l24_crc_error", 32'(crcerr[0]), 32'(0));
    check("l24_latency", 32'(edges), CRC_ON ? 32'(29) : 32'(27));

    // Host gaps of 5 cycles, restarting from DONE
    base = en_cnt[0];
    run_load(0, 24'hA50FC3, 5, 1'b0, 1'b0, edges);
    check("gap_en_cycles", 32'(en_cnt[0] - base), 32'(24));
    check("gap_chain", 32'(chain[0]), 32'h00A50FC3);

    // 20-bit chain: partial last word
    base = en_cnt[1];
    run_load(1, 24'hA50FC3, 0, 1'b0, 1'b0, edges);
    check("l20_en_cycles", 32'(en_cnt[1] - base), 32'(20));
    check("l20_chain", 32'(chain[1][19:0]), 32'h000A50FC);
    check("l20_done", 32'(done[1]), 32'(1));
    check("l20_latency", 32'(edges), CRC_ON ? 32'(25) : 32'(23));
    if (!CRC_ON) check("l20_done_after_last_bit", 32'(last_en[1]), 32'(cyc - 1));

    // Reset while bit 10 is on the chain head
    base = en_cnt[0];
    pulse_start(0);
    send_word(0, 8'hA5, 0);
    send_word(0, 8'h0F, 0);
    n = 0;
    while ((en_cnt[0] - base) < 9 && n < 50) begin tick(); n++; end
    check("mid_bit10_enabled", 32'(cen[0]), 32'(1));
    rst_n = 1'b0;
    tick();
    check("mid_rst_outs", 32'({cen[0], busy[0], ready[0], done[0]}), 32'(0));
    rst_n = 1'b1;
    tick();
    base = en_cnt[0];
    run_load(0, 24'hA50FC3, 0, 1'b0, 1'b0, edges);
    check("post_rst_en_cycles", 32'(en_cnt[0] - base), 32'(24));
    check("post_rst_chain", 32'(chain[0]), 32'h00A50FC3);

    // start pulsed during SHIFT must not disturb the stream
    base = en_cnt[0];
    run_load(0, 24'h3C96E1, 0, 1'b0, 1'b1, edges);
    check("midstart_en_cycles", 32'(en_cnt[0] - base), 32'(24));
    check("midstart_chain", 32'(chain[0]), 32'h003C96E1);
    check("midstart_latency", 32'(edges), CRC_ON ? 32'(29) : 32'(27));

    // One data bit flipped relative to the CRC the host sends
    base = en_cnt[0];
    run_load(0, 24'hA50FC3, 0, 1'b1, 1'b0, edges);
    check("flip_chain", 32'(chain[0]), 32'h00A40FC3);
    check("flip_done", 32'(done[0]), 32'(1));
    check("flip_crc_error", 32'(crcerr[0]), CRC_ON ? 32'(1) : 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
